fpu_sequencer: RTL

Issue/collect stage directly upstream of the FPU controller. It accepts one floating-point operation from the core pipeline and latches the opcode and operands. It holds them stable while it drives the controller's stb/ack handshake. It then captures the result, returns it to the core as a one-cycle valid pulse, and reports illegal opcodes and hung operations.

---
 rtl/fpu_sequencer_if.sv | 34 +++
 rtl/fpu_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/fpu_sequencer_if.sv
// Core-side request/response and FPU-controller handshake signals of the sequencer.
// master = core pipeline plus FPU controller environment; slave = the sequencer itself.
interface fpu_sequencer_if;
   logic        start;
   logic [3:0]  op_in;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;
   logic        error;
   logic [3:0]  fpu_op;
   logic [31:0] fpu_in1;
   logic [31:0] fpu_in2;
   logic        fpu_in1_stb;
   logic        fpu_in2_stb;
   logic        fpu_in1_ack;
   logic        fpu_in2_ack;
   logic [31:0] fpu_out;
   logic        fpu_out_stb;
   logic        fpu_out_ack;

   modport master (
      output start, op_in, rs1, rs2, fpu_in1_ack, fpu_in2_ack, fpu_out, fpu_out_stb,
      input  busy, result_valid, result, error, fpu_op, fpu_in1, fpu_in2,
             fpu_in1_stb, fpu_in2_stb, fpu_out_ack
   );

   modport slave (
      input  start, op_in, rs1, rs2, fpu_in1_ack, fpu_in2_ack, fpu_out, fpu_out_stb,
      output busy, result_valid, result, error, fpu_op, fpu_in1, fpu_in2,
             fpu_in1_stb, fpu_in2_stb, fpu_out_ack
   );
endinterface

// File: rtl/fpu_sequencer.sv
// Issue/collect stage ahead of the FPU controller: latches one operation, runs the
// operand/result handshake, returns a one-cycle result pulse, flags illegal ops and hangs.
module fpu_sequencer #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
   input logic             clk,
   input logic             reset_n,
   fpu_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, ILL} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             a1, a2;
   logic             both_acked, timeout_hit, capture;

   logic [31:0]      result_q, in1_q, in2_q;
   logic [3:0]       op_q;
   logic             error_q, valid_q, out_ack_q;

   always_comb begin
      both_acked  = (a1 | bus.fpu_in1_ack) & (a2 | bus.fpu_in2_ack);
      // fires on the edge where the cycle count since leaving IDLE reaches TIMEOUT
      timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
      capture     = (state == WAIT) && bus.fpu_out_stb;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = bus.op_in[3] ? ILL : SEND;
         SEND: if (timeout_hit) state_nxt = ACK;
               else if (both_acked) state_nxt = WAIT;
         WAIT: if (capture || timeout_hit) state_nxt = ACK;
         ACK:  state_nxt = IDLE;
         ILL:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         a1        <= 1'b0;
         a2        <= 1'b0;
         result_q  <= '0;
         error_q   <= 1'b0;
         valid_q   <= 1'b0;
         out_ack_q <= 1'b0;
         op_q      <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
      end else begin
         state     <= state_nxt;
         valid_q   <= 1'b0;
         out_ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q <= bus.op_in;
                  if (!bus.op_in[3]) begin
                     in1_q <= bus.rs1;
                     in2_q <= bus.rs2;
                     cnt   <= '0;
                     a1    <= 1'b0;
                     a2    <= 1'b0;
                  end
               end
            end
            SEND: begin
               cnt <= cnt + 1'b1;
               a1  <= a1 | bus.fpu_in1_ack;
               a2  <= a2 | bus.fpu_in2_ack;
               if (timeout_hit) begin
                  result_q <= '0;
                  error_q  <= 1'b1;
                  valid_q  <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               // a real result beats a timeout landing on the same edge
               if (capture) begin
                  result_q  <= bus.fpu_out;
                  error_q   <= 1'b0;
                  valid_q   <= 1'b1;
                  out_ack_q <= 1'b1;
               end else if (timeout_hit) begin
                  result_q <= '0;
                  error_q  <= 1'b1;
                  valid_q  <= 1'b1;
               end
            end
            ILL: begin
               result_q <= '0;
               error_q  <= 1'b1;
               valid_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.fpu_in1_stb  = (state == SEND);
   assign bus.fpu_in2_stb  = (state == SEND);
   assign bus.result_valid = valid_q;
   assign bus.result       = result_q;
   assign bus.error        = error_q;
   assign bus.fpu_out_ack  = out_ack_q;
   assign bus.fpu_op       = op_q;
   assign bus.fpu_in1      = in1_q;
   assign bus.fpu_in2      = in2_q;

endmodule
